// File: rtl/register_file_if.sv
// register_file_if: bus connecting the register file to its client.
//   master : drives the write port, read enable and read addresses; samples read data and count.
//   slave  : the register file itself.
// Signals:
//   writeEnable/writeAddr/writeData : synchronous write port
//   readEnable/readAddrA/readAddrB  : read request, sampled on the rising edge
//   readDataA/readDataB             : registered read data
//   writeCount                      : saturating count of committed writes
interface register_file_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  writeEnable;
   logic [ADDR_WIDTH-1:0] writeAddr;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  readEnable;
   logic [ADDR_WIDTH-1:0] readAddrA;
   logic [ADDR_WIDTH-1:0] readAddrB;
   logic [DATA_WIDTH-1:0] readDataA;
   logic [DATA_WIDTH-1:0] readDataB;
   logic [7:0]            writeCount;

   modport master (
      output writeEnable, writeAddr, writeData, readEnable, readAddrA, readAddrB,
      input  readDataA, readDataB, writeCount
   );

   modport slave (
      input  writeEnable, writeAddr, writeData, readEnable, readAddrA, readAddrB,
      output readDataA, readDataB, writeCount
   );
endinterface

// File: rtl/register_file.sv
// register_file: DEPTH x DATA_WIDTH register file, one synchronous write port, two registered
// read ports, register 0 hardwired to zero, optional same-edge write-to-read forwarding.
// Ports:
//   clock  : rising-edge clock
//   resetN : asynchronous active-low reset; clears storage, read outputs and write count
//   bus    : register_file_if slave modport (write port, read ports, writeCount)
module register_file #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned BYPASS     = 1
) (
   input logic            clock,
   input logic            resetN,
   register_file_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
   logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wr_ok;

   // Writes to register 0 are discarded entirely, including the count.
   assign wr_ok = bus.writeEnable && (bus.writeAddr != '0);

   always_comb begin
      mem_d = mem_q;
      if (wr_ok) begin
         mem_d[bus.writeAddr] = bus.writeData;
      end
      mem_d[0] = '0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wr_ok && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Read ports hold when readEnable is low; forwarding only applies to nonzero addresses
   // because wr_ok already excludes register 0.
   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (bus.readEnable) begin
         if (bus.readAddrA == '0) begin
            rd_a_d = '0;
         end else if ((BYPASS != 0) && wr_ok && (bus.writeAddr == bus.readAddrA)) begin
            rd_a_d = bus.writeData;
         end else begin
            rd_a_d = mem_q[bus.readAddrA];
         end

         if (bus.readAddrB == '0) begin
            rd_b_d = '0;
         end else if ((BYPASS != 0) && wr_ok && (bus.writeAddr == bus.readAddrB)) begin
            rd_b_d = bus.writeData;
         end else begin
            rd_b_d = mem_q[bus.readAddrB];
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         mem_q  <= '{default: '0};
         rd_a_q <= '0;
         rd_b_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.readDataA  = rd_a_q;
   assign bus.readDataB  = rd_b_q;
   assign bus.writeCount = cnt_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file (BYPASS=1).
module tb_register_file;
   logic clock;
   logic resetN;

   register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   register_file #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(3),
      .BYPASS    (1)
   ) dut (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       we;
      logic [2:0] waddr;
      logic [7:0] wdata;
      logic       re;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [7:0] ec;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] waddr, input logic [7:0] wdata,
                        input logic re, input logic [2:0] ra, input logic [2:0] rb);
      bus.writeEnable = we;
      bus.writeAddr   = waddr;
      bus.writeData   = wdata;
      bus.readEnable  = re;
      bus.readAddrA   = ra;
      bus.readAddrB   = rb;
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Table: one edge per row, outputs checked just after that edge.
      vecs[0]  = '{1'b1, 3'd3, 8'hAF, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'd1};
      vecs[1]  = '{1'b1, 3'd5, 8'hAC, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'd2};
      vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd5, 8'hAF, 8'hAC, 8'd2};
      vecs[3]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd3, 8'h00, 8'hAF, 8'd2};
      vecs[4]  = '{1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 3'd2, 8'h11, 8'h11, 8'd3};
      vecs[5]  = '{1'b1, 3'd2, 8'hF0, 1'b1, 3'd2, 3'd5, 8'hF0, 8'hAC, 8'd4};
      vecs[6]  = '{1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 3'd2, 8'hAA, 8'hF0, 8'd5};
      vecs[7]  = '{1'b1, 3'd4, 8'h55, 1'b0, 3'd4, 3'd2, 8'hAA, 8'hF0, 8'd6};
      vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd2, 8'hAA, 8'hF0, 8'd6};
      vecs[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd1, 8'h55, 8'h00, 8'd6};
      vecs[10] = '{1'b1, 3'd7, 8'h3C, 1'b1, 3'd7, 3'd6, 8'h3C, 8'h00, 8'd7};
      vecs[11] = '{1'b1, 3'd6, 8'h01, 1'b1, 3'd6, 3'd7, 8'h01, 8'h3C, 8'd8};
      vecs[12] = '{1'b1, 3'd1, 8'h80, 1'b1, 3'd1, 3'd1, 8'h80, 8'h80, 8'd9};

      resetN = 1'b1;
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
      #1 resetN = 1'b0;
      #1;
      check("reset_a", bus.readDataA, 8'h00);
      check("reset_b", bus.readDataB, 8'h00);
      check("reset_cnt", bus.writeCount, 8'h00);
      #10 resetN = 1'b1;

      // Load r1..r7 with nonzero data, then read r7/r1 to get nonzero outputs.
      for (int i = 1; i < 8; i++) begin
         drive(1'b1, 3'(i), 8'(8'h10 * i + i), 1'b0, 3'd0, 3'd0);
         step();
      end
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd1);
      step();
      check("load_a", bus.readDataA, 8'h77);
      check("load_b", bus.readDataB, 8'h11);
      check("load_cnt", bus.writeCount, 8'd7);

      // Asynchronous reset between edges clears outputs immediately.
      #2 resetN = 1'b0;
      #1;
      check("async_a", bus.readDataA, 8'h00);
      check("async_b", bus.readDataB, 8'h00);
      check("async_cnt", bus.writeCount, 8'h00);

      // Write and read presented while in reset are ignored.
      drive(1'b1, 3'd3, 8'hEE, 1'b1, 3'd3, 3'd4);
      step();
      check("inreset_a", bus.readDataA, 8'h00);
      check("inreset_cnt", bus.writeCount, 8'h00);
      resetN = 1'b1;

      // All registers read back zero after reset.
      for (int i = 1; i < 8; i += 2) begin
         drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 3'(i + 1));
         step();
         check($sformatf("clr_a_r%0d", i), bus.readDataA, 8'h00);
         if (i < 7) check($sformatf("clr_b_r%0d", i + 1), bus.readDataB, 8'h00);
      end

      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].re, vecs[v].ra, vecs[v].rb);
         step();
         check($sformatf("vec%0d_a", v), bus.readDataA, vecs[v].ea);
         check($sformatf("vec%0d_b", v), bus.readDataB, vecs[v].eb);
         check($sformatf("vec%0d_cnt", v), bus.writeCount, vecs[v].ec);
      end

      // Saturation: 300 writes to r1, count stops at 255, storage keeps updating.
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 3'd1, 8'(i), 1'b0, 3'd0, 3'd0);
         step();
      end
      check("sat_cnt", bus.writeCount, 8'hFF);
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd7);
      step();
      check("sat_r1", bus.readDataA, 8'h2B);
      check("sat_r7", bus.readDataB, 8'h3C);
      drive(1'b1, 3'd5, 8'h99, 1'b0, 3'd0, 3'd0);
      step();
      check("sat_hold_cnt", bus.writeCount, 8'hFF);
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd0);
      step();
      check("sat_r5", bus.readDataA, 8'h99);
      check("sat_r0", bus.readDataB, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
